hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised hazard and control-flow unit for the 5-stage MIPS pipeline; it sits beside the ID stage.
//  - Detects load-use hazards and holds PC/IF-ID for a configurable number of cycles.
//  - Resolves branches and jumps in ID and drives the PC redirect and the IF-ID flush.
//  - Keeps saturating stall and flush statistics counters.
// PARAMETERS
//  DATA_W      32  datapath and PC width
//  RA_W        5   register-address width
//  LOAD_LAT    1   bubble cycles inserted per load-use hazard (1..15)
//  DELAY_SLOT  0   1: instruction after a taken branch/jump is kept; 0: it is flushed
//  CNT_W       16  width of the statistics counters
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous reset, active high
//  id_valid     in   1       ID stage holds a valid instruction
//  id_rs        in   RA_W    ID source register rs
//  id_rt        in   RA_W    ID source register rt
//  id_use_rs    in   1       ID instruction reads rs
//  id_use_rt    in   1       ID instruction reads rt
//  ex_load      in   1       EX stage holds a load (lw/lh/lb/lhu/lbu)
//  ex_rt        in   RA_W    destination register of the EX load
//  id_branch    in   1       ID instruction is a conditional branch
//  id_br_type   in   3       0 beq, 1 bne, 2 bgez, 3 bgtz, 4 blez, 5 bltz, 6-7 never taken
//  id_jump      in   2       00 none, 01 j, 10 jr, 11 jal
//  id_imm       in   16      branch offset in words
//  id_idx       in   26      jump index
//  id_pc        in   DATA_W  PC of the ID instruction
//  rs_val       in   DATA_W  forwarded rs value
//  rt_val       in   DATA_W  forwarded rt value
//  pc_write     out  1       PC register enable
//  ifid_write   out  1       IF-ID register enable
//  ifid_flush   out  1       IF-ID register clear (insert nop)
//  idex_bubble  out  1       ID-EX control bits forced to zero
//  pc_src       out  1       1: PC takes target_pc next edge
//  target_pc    out  DATA_W  redirect address
//  stall_cnt    out  CNT_W   total stall cycles, saturating
//  flush_cnt    out  CNT_W   total taken redirects, saturating
// BEHAVIOUR
//  - FSM has two states: RUN and STALL. A 4-bit counter rem holds the remaining stall cycles.
//  - Outputs are combinational from the current-cycle inputs plus the registered state/rem/counters.
//  - Defaults: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pc_src=0, target_pc=0.
//  - Hazard condition: hz = id_valid & ex_load & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
//  - RUN & hz in cycle T:
//      - pc_write=0, ifid_write=0, idex_bubble=1.
//      - Branch and jump evaluation is suppressed.
//      - If LOAD_LAT>1: go to STALL with rem=LOAD_LAT-1. Otherwise stay in RUN.
//  - STALL:
//      - Same outputs as RUN & hz; all ID/EX inputs are ignored.
//      - rem decrements each cycle; at rem==1 go to RUN.
//      - A load-use stall therefore lasts exactly LOAD_LAT cycles.
//  - RUN & !hz & id_valid: branch/jump resolution.
//      - Taken when: beq rs==rt; bne rs!=rt; bgez rs>=0; bgtz rs>0; blez rs<=0; bltz rs<0. Comparisons are signed.
//      - Branch target = id_pc+4+(sext(id_imm)<<2), modulo 2^DATA_W.
//      - j/jal target = {pc4[DATA_W-1:28], id_idx, 2'b00}, where pc4=id_pc+4.
//      - jr target = rs_val.
//      - Taken branch or any jump: pc_src=1, target_pc=target, ifid_flush=!DELAY_SLOT, pc_write=1, ifid_write=1.
//      - Not-taken branch: defaults only.
//      - Branch and jump together: branch has priority; the jump is ignored.
//  - id_valid=0 in RUN: defaults only.
//  - Statistics, updated on the clock edge:
//      - stall_cnt += 1 for each cycle with pc_write=0.
//      - flush_cnt += 1 for each cycle with pc_src=1.
//      - Both saturate at all-ones and never wrap.
//  - Reset: state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
//      - Reset asserted mid-stall aborts the stall. The cycle after reset shows default outputs unless hz is true.
// TESTING
//  - LOAD_LAT=1: lw $3 in EX, ID add reads $3 -> one cycle with pc_write=0, idex_bubble=1; next cycle defaults; stall_cnt=1.
//  - LOAD_LAT=3, same hazard -> exactly 3 stall cycles, including while ex_load=0 in cycles 2-3; then RUN.
//  - ex_rt=0 with id_rs=0 and ex_load=1 -> no stall.
//  - beq with rs_val=rt_val=5, id_pc=0x100, imm=0xFFFF -> pc_src=1, target_pc=0x100, ifid_flush=1 (DELAY_SLOT=0), flush_cnt=1.
//  - bltz rs_val=0x80000000 -> taken. jr rs_val=0x400 -> target 0x400. j with id_pc=0xF0000000, idx=1 -> 0xF0000004.
//  - Reset asserted in the 2nd cycle of a LOAD_LAT=3 stall -> next cycle defaults, counters 0. CNT_W=2 after 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard and control-flow unit beside the ID stage: load-use stall sequencing,
// branch/jump resolution with PC redirect, and saturating stall/flush statistics.
module hazard_ctrl_unit #(
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int LOAD_LAT   = 1,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_rt,
  input  logic              id_branch,
  input  logic [2:0]        id_br_type,
  input  logic [1:0]        id_jump,
  input  logic [15:0]       id_imm,
  input  logic [25:0]       id_idx,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pc_src,
  output logic [DATA_W-1:0] target_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              dbg_state,
  output logic [3:0]        dbg_rem
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [3:0]        LAT_M1         = 4'(LOAD_LAT - 1);
  localparam logic              FLUSH_ON_TAKEN = (DELAY_SLOT == 0);
  localparam logic [DATA_W-1:0] PC_STEP        = DATA_W'(4);
  localparam logic [CNT_W-1:0]  CNT_ONE        = CNT_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              hz;
  logic              br_taken;
  logic              rs_neg;
  logic              rs_zero;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] jmp_target;

  // Hazard detection and target arithmetic are pure functions of ID/EX inputs.
  always_comb begin
    hz = id_valid & ex_load & (ex_rt != '0) &
         ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));

    rs_neg  = rs_val[DATA_W-1];
    rs_zero = (rs_val == '0);

    br_taken = 1'b0;
    case (id_br_type)
      3'd0:    br_taken = (rs_val == rt_val);
      3'd1:    br_taken = (rs_val != rt_val);
      3'd2:    br_taken = !rs_neg;
      3'd3:    br_taken = !rs_neg && !rs_zero;
      3'd4:    br_taken = rs_neg || rs_zero;
      3'd5:    br_taken = rs_neg;
      default: br_taken = 1'b0;
    endcase

    pc4        = id_pc + PC_STEP;
    imm_sext   = {{(DATA_W-16){id_imm[15]}}, id_imm};
    br_target  = pc4 + (imm_sext << 2);
    jmp_target = pc4;
    jmp_target[27:0] = {id_idx, 2'b00};
  end

  // Next-state and pipeline-control outputs.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_src      = 1'b0;
    target_pc   = '0;

    case (state_q)
      ST_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (rem_q <= 4'd1) begin
          state_d = ST_RUN;
          rem_d   = 4'd0;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end

      ST_RUN: begin
        if (hz) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_STALL;
            rem_d   = LAT_M1;
          end
        end else if (id_valid) begin
          // A conditional branch owns the slot; a simultaneous jump is ignored.
          if (id_branch) begin
            if (br_taken) begin
              pc_src     = 1'b1;
              target_pc  = br_target;
              ifid_flush = FLUSH_ON_TAKEN;
            end
          end else if (id_jump != 2'b00) begin
            pc_src     = 1'b1;
            target_pc  = (id_jump == 2'b10) ? rs_val : jmp_target;
            ifid_flush = FLUSH_ON_TAKEN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        rem_d   = 4'd0;
      end
    endcase
  end

  // Statistics saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (pc_src && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;
  assign dbg_rem   = rem_q;

endmodule
